csa_final_adder: RTL and testbench

Multi-cycle carry-propagate adder that resolves the redundant sum/carry vector pair produced by the final Wallace-tree CSA layer into a single binary result. It sits directly downstream of the last CSA stage: the CSA's `u` (bitwise sum) and `v` (carry vector, already shifted left with `v[0] = 0`) feed this block. It adds them one CHUNK-bit slice per cycle, rippling the slice carry through a register. A valid/ready handshake on both sides lets the tree and the consumer stall independently.

---
 rtl/csa_final_adder.sv | 126 ++++++++++++
 tb/tb_csa_final_adder.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_final_adder.sv
// Multi-cycle carry-propagate adder that resolves a CSA sum/carry vector pair into binary.
// Adds one CHUNK-bit slice per cycle, rippling the slice carry through a register.
module csa_final_adder #(
    parameter int unsigned W     = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] u,
    input  logic [W-1:0] v,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned CHUNK_NZ = (CHUNK == 0) ? 1 : CHUNK;
    localparam int unsigned NCH      = W / CHUNK_NZ;
    localparam int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if ((CHUNK < 1) || (CHUNK > W) || ((W % CHUNK_NZ) != 0)) begin : g_bad_params
        $error("csa_final_adder: CHUNK must divide W and satisfy 1 <= CHUNK <= W");
    end

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  u_q, u_d;
    logic [W-1:0]  v_q, v_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;

    logic [CHUNK-1:0] u_slice;
    logic [CHUNK-1:0] v_slice;
    logic [CHUNK:0]   slice_add;

    // Decoded slice mux keeps the part-select index a compile-time constant.
    always_comb begin
        u_slice = '0;
        v_slice = '0;
        for (int j = 0; j < NCH; j++) begin
            if (idx_q == CW'(j)) begin
                u_slice = u_q[j*CHUNK +: CHUNK];
                v_slice = v_q[j*CHUNK +: CHUNK];
            end
        end
        slice_add = {1'b0, u_slice} + {1'b0, v_slice} + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    u_d     = u;
                    v_d     = v;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int j = 0; j < NCH; j++) begin
                    if (idx_q == CW'(j)) begin
                        sum_d[j*CHUNK +: CHUNK] = slice_add[CHUNK-1:0];
                    end
                end
                carry_d = slice_add[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_add[CHUNK];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake outputs depend on state only.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_csa_final_adder.sv
// Self-checking bench for csa_final_adder: directed scenarios plus randomized streams
// at CHUNK = 16, 8 and 64, scored against plain 65-bit addition.
module tb_csa_final_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid [3];
    logic        in_ready [3];
    logic [63:0] u_s      [3];
    logic [63:0] v_s      [3];
    logic        out_valid[3];
    logic        out_ready[3];
    logic [63:0] sum_s    [3];
    logic        cout_s   [3];

    int checks = 0;
    int errors = 0;

    csa_final_adder #(.W(64), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .u(u_s[0]), .v(v_s[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum_s[0]), .cout(cout_s[0])
    );

    csa_final_adder #(.W(64), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .u(u_s[1]), .v(v_s[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum_s[1]), .cout(cout_s[1])
    );

    csa_final_adder #(.W(64), .CHUNK(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .u(u_s[2]), .v(v_s[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum_s[2]), .cout(cout_s[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            u_s[i]       = 64'd0;
            v_s[i]       = 64'd0;
        end
    endtask

    // Handshake at the upcoming edge (cycle T); lat = cycles from T until out_valid is seen.
    task automatic run_one(input int i, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] s, output logic c, output int lat);
        in_valid[i] = 1'b1;
        u_s[i] = a;
        v_s[i] = b;
        tick();
        in_valid[i] = 1'b0;
        u_s[i] = ~a;
        v_s[i] = ~b;
        lat = 1;
        while (!out_valid[i] && lat < 100) begin
            tick();
            lat++;
        end
        s = sum_s[i];
        c = cout_s[i];
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 1", i, in_ready[i]);
            end
            checks++;
            if (out_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, out_valid[i]);
            end
            checks++;
            if (sum_s[i] !== 64'd0 || cout_s[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_result[%0d]: got %b_%h expected 0_0", i, cout_s[i], sum_s[i]);
            end
        end
    endtask

    task automatic test_reset_vs_valid();
        rst = 1'b1;
        in_valid[0] = 1'b1;
        u_s[0] = 64'd5;
        v_s[0] = 64'd6;
        tick();
        rst = 1'b0;
        in_valid[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_wins_capture: cyc %0d got in_ready=%b out_valid=%b expected 1/0",
                         c, in_ready[0], out_valid[0]);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_idle_ready: got %b expected 1", in_ready[0]);
        end
        in_valid[0] = 1'b1;
        u_s[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        v_s[0] = 64'h1;
        tick();
        in_valid[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL wrap_in_ready T+%0d: got %b expected 0", c, in_ready[0]);
            end
            checks++;
            if (out_valid[0] !== (c == 5)) begin
                errors++;
                $display("FAIL wrap_out_valid T+%0d: got %b expected %b", c, out_valid[0], c == 5);
            end
            if (c == 5) begin
                checks++;
                if (sum_s[0] !== 64'd0 || cout_s[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_result: got %b_%h expected 1_0", cout_s[0], sum_s[0]);
                end
                out_ready[0] = 1'b1;
            end
            tick();
        end
        out_ready[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_after_done: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_csa();
        logic [63:0] x, y, z, cu, cv, s;
        logic c;
        int lat;
        x = 64'd3;
        y = 64'd5;
        z = 64'd6;
        cu = x ^ y ^ z;
        cv = ((x & y) | (x & z) | (y & z)) << 1;
        run_one(0, cu, cv, s, c, lat);
        checks++;
        if (s !== 64'hE || c !== 1'b0 || lat != 5) begin
            errors++;
            $display("FAIL csa_vector: got %b_%h lat %0d expected 0_e lat 5", c, s, lat);
        end
    endtask

    task automatic test_chunk_boundary();
        logic [63:0] s;
        logic c;
        int lat;
        run_one(0, 64'h0000_0000_0000_FFFF, 64'h1, s, c, lat);
        checks++;
        if (s !== 64'h0000_0000_0001_0000 || c !== 1'b0 || lat != 5) begin
            errors++;
            $display("FAIL chunk_carry_lo: got %b_%h lat %0d expected 0_10000 lat 5", c, s, lat);
        end
        run_one(0, 64'h0000_FFFF_FFFF_FFFF, 64'h1, s, c, lat);
        checks++;
        if (s !== 64'h0001_0000_0000_0000 || c !== 1'b0 || lat != 5) begin
            errors++;
            $display("FAIL chunk_carry_hi: got %b_%h lat %0d expected 0_1000000000000 lat 5",
                     c, s, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, a2, b2;
        logic [64:0] e1, e2;
        int w;
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        a2 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        e1 = {1'b0, a} + {1'b0, b};
        e2 = {1'b0, a2} + {1'b0, b2};
        in_valid[0] = 1'b1;
        u_s[0] = a;
        v_s[0] = b;
        tick();
        in_valid[0] = 1'b0;
        w = 0;
        while (!out_valid[0] && w < 100) begin
            tick();
            w++;
        end
        checks++;
        if (out_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_result: got out_valid=%b expected 1", out_valid[0]);
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_valid[0] = 1'b1;
                u_s[0] = a2;
                v_s[0] = b2;
            end
            checks++;
            if ({cout_s[0], sum_s[0]} !== e1 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc %0d: got %h rdy=%b vld=%b expected %h rdy=0 vld=1",
                         c, {cout_s[0], sum_s[0]}, in_ready[0], out_valid[0], e1);
            end
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || {cout_s[0], sum_s[0]} !== e1) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b vld=%b res=%h expected 1/0 res=%h",
                     in_ready[0], out_valid[0], {cout_s[0], sum_s[0]}, e1);
        end
        tick();
        in_valid[0] = 1'b0;
        u_s[0] = 64'hDEAD_BEEF_0BAD_F00D;
        v_s[0] = 64'h1234_5678_9ABC_DEF0;
        checks++;
        if (in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: got in_ready=%b expected 0", in_ready[0]);
        end
        w = 1;
        while (!out_valid[0] && w < 100) begin
            tick();
            w++;
        end
        checks++;
        if ({cout_s[0], sum_s[0]} !== e2 || w != 5) begin
            errors++;
            $display("FAIL bp_second_result: got %h lat %0d expected %h lat 5",
                     {cout_s[0], sum_s[0]}, w, e2);
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_add();
        logic [63:0] s;
        logic c;
        int lat;
        in_valid[0] = 1'b1;
        u_s[0] = {$urandom, $urandom} | 64'h1;
        v_s[0] = {$urandom, $urandom};
        tick();
        in_valid[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || sum_s[0] !== 64'd0 ||
            cout_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_add_reset: got vld=%b rdy=%b res=%b_%h expected 0/1 0_0",
                     out_valid[0], in_ready[0], cout_s[0], sum_s[0]);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (out_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL mid_add_no_result cyc %0d: got out_valid=%b expected 0",
                         k, out_valid[0]);
            end
            tick();
        end
        run_one(0, 64'd2, 64'd3, s, c, lat);
        checks++;
        if (s !== 64'd5 || c !== 1'b0 || lat != 5) begin
            errors++;
            $display("FAIL mid_add_fresh: got %b_%h lat %0d expected 0_5 lat 5", c, s, lat);
        end
    endtask

    task automatic test_latency_widths();
        logic [63:0] a, b, s;
        logic c;
        int lat;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        run_one(2, a, b, s, c, lat);
        checks++;
        if ({c, s} !== ({1'b0, a} + {1'b0, b}) || lat != 2) begin
            errors++;
            $display("FAIL chunk64_single: got %b_%h lat %0d expected %h lat 2",
                     c, s, lat, {1'b0, a} + {1'b0, b});
        end
        run_one(1, a, b, s, c, lat);
        checks++;
        if ({c, s} !== ({1'b0, a} + {1'b0, b}) || lat != 9) begin
            errors++;
            $display("FAIL chunk8_single: got %b_%h lat %0d expected %h lat 9",
                     c, s, lat, {1'b0, a} + {1'b0, b});
        end
    endtask

    task automatic test_random(input int i, input int n);
        logic [64:0] expq[$];
        int got;
        got = 0;
        fork
            begin : producer
                for (int k = 0; k < n; k++) begin
                    logic [63:0] a, b;
                    int gap, w;
                    bit hs;
                    gap = $urandom_range(0, 3);
                    repeat (gap) tick();
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    in_valid[i] = 1'b1;
                    u_s[i] = a;
                    v_s[i] = b;
                    hs = 1'b0;
                    w = 0;
                    while (!hs && w < 200) begin
                        hs = in_ready[i];
                        tick();
                        w++;
                    end
                    in_valid[i] = 1'b0;
                    u_s[i] = {$urandom, $urandom};
                    v_s[i] = {$urandom, $urandom};
                    checks++;
                    if (!hs) begin
                        errors++;
                        $display("FAIL rand_accept[%0d] op %0d: got no in_ready expected accept", i, k);
                        break;
                    end
                    expq.push_back({1'b0, a} + {1'b0, b});
                end
            end
            begin : consumer
                int budget;
                logic [64:0] e;
                budget = 0;
                while (got < n && budget < 25 * n) begin
                    out_ready[i] = ($urandom_range(0, 2) != 0);
                    if (out_valid[i] && out_ready[i]) begin
                        checks++;
                        if (expq.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra[%0d]: got %h expected no output",
                                     i, {cout_s[i], sum_s[i]});
                        end else begin
                            e = expq.pop_front();
                            if ({cout_s[i], sum_s[i]} !== e) begin
                                errors++;
                                $display("FAIL rand_result[%0d] #%0d: got %h expected %h",
                                         i, got, {cout_s[i], sum_s[i]}, e);
                            end
                        end
                        got++;
                    end
                    tick();
                    budget++;
                end
                out_ready[i] = 1'b0;
            end
        join
        checks++;
        if (got != n || expq.size() != 0) begin
            errors++;
            $display("FAIL rand_count[%0d]: got %0d outputs (%0d pending) expected %0d",
                     i, got, expq.size(), n);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_reset_vs_valid();
        test_wrap();
        test_csa();
        test_chunk_boundary();
        test_backpressure();
        test_reset_mid_add();
        test_latency_widths();
        test_random(0, 1000);
        test_random(1, 1000);
        test_random(2, 1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
